dmem_ctrl: RTL

Parametrised data-memory controller for the single-cycle MIPS core: replaces the fixed 4096×32, word-only, negedge-clocked data RAM with a byte-addressable, byte-lane-writable store, configurable wait states, a req/ready stall handshake and optional memory-mapped I/O. Sits between the core's ALU result / store-data path and the writeback mux; the core freezes its PC while `stall` is high.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_bank.sv | 24 ++
 rtl/dmem_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access size encoding,
// controller FSM states and the memory-mapped I/O register map.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // The I/O window spans 64 KiB starting at MMIO_BASE.
  localparam int          MMIO_SPAN_W  = 16;
  localparam logic [15:0] MMIO_OFS_LED = 16'h0000;
  localparam logic [15:0] MMIO_OFS_SW  = 16'h0004;
  localparam logic [15:0] MMIO_OFS_CYC = 16'h0008;

  // Request fields captured when an access is accepted.
  typedef struct packed {
    logic        we;
    size_e       size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  // Alignment / encoding fault for a RAM or MMIO access.
  function automatic logic access_fault(input size_e sz, input logic [1:0] a);
    return (sz == SZ_BAD) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM, 2**ADDR_W x 32, with per-byte write enables.
// Read-first: q shows the contents before a same-cycle write.
module dmem_bank #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-lane writes and registered read of the addressed word.
  // NOTE: the array is never reset so synthesis can map it onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-addressable RAM with wait states, a req/ready
// stall handshake and, when DMEM_MMIO_EN is defined, an I/O window at
// MMIO_BASE (LED register, switch input, free-running cycle counter).
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall,
  input  logic [31:0] io_in,
  output logic [31:0] io_out
);

  state_e             state;
  logic [3:0]         cnt;
  acc_t               lat;
  logic [31:0]        q;
  logic [ADDR_W-1:0]  ram_addr;
  logic [3:0]         be;
  logic [31:0]        ram_wdata;
  logic [31:0]        load_val;
  logic [31:0]        rd_val;
  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic               hit;
  logic               fault;
  logic               commit;
  logic               fire;

  assign stall = req & ~ready;
  assign fire  = (state == ST_WAIT) && (cnt == 4'd0);

  // While idle the RAM looks up the incoming address so the word is ready by
  // the time the access fires; afterwards it follows the latched address.
  assign ram_addr = (state == ST_IDLE) ? addr[ADDR_W+1:2] : lat.addr[ADDR_W+1:2];

`ifdef DMEM_MMIO_EN
  logic [31:0]            io_q;
  logic [31:0]            cyc;
  logic [MMIO_SPAN_W-1:0] ofs;
  logic                   mmio_fault;

  assign ofs    = lat.addr[MMIO_SPAN_W-1:0];
  assign hit    = (lat.addr[31:MMIO_SPAN_W] == MMIO_BASE[31:MMIO_SPAN_W]);
  assign io_out = io_q;

  // Window decode: only aligned words at the three defined offsets are legal.
  always_comb begin
    mmio_fault = 1'b0;
    rd_val     = load_val;
    if (hit) begin
      mmio_fault = (lat.size != SZ_WORD) ||
                   !(ofs == MMIO_OFS_LED || ofs == MMIO_OFS_SW || ofs == MMIO_OFS_CYC);
      unique case (ofs)
        MMIO_OFS_LED: rd_val = io_q;
        MMIO_OFS_SW:  rd_val = io_in;
        default:      rd_val = cyc;
      endcase
    end
  end

  assign fault = access_fault(lat.size, lat.addr[1:0]) | mmio_fault;

  // Free-running cycle counter, wraps naturally at 2**32.
  always_ff @(posedge clk) begin
    if (!rst) cyc <= '0;
    else      cyc <= cyc + 32'd1;
  end

  // LED register, written by an accepted word store to offset 0.
  always_ff @(posedge clk) begin
    if (!rst)
      io_q <= '0;
    else if (fire && hit && !fault && lat.we && ofs == MMIO_OFS_LED)
      io_q <= lat.wdata;
  end

  logic unused_bits;
  assign unused_bits = ^{addr, lat.addr};
`else
  assign hit    = 1'b0;
  assign rd_val = load_val;
  assign fault  = access_fault(lat.size, lat.addr[1:0]);
  assign io_out = '0;

  logic unused_bits;
  assign unused_bits = ^{addr, lat.addr, io_in, MMIO_BASE};
`endif

  assign commit = fire && lat.we && !fault && !hit && rst;

  // Byte-lane enables and lane-replicated store data for the RAM.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    be        = 4'b0000;
    ram_wdata = lat.wdata;
    unique case (lat.size)
      SZ_BYTE: begin
        be        = 4'b0001 << lat.addr[1:0];
        ram_wdata = {4{lat.wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = lat.addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{lat.wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (!commit) be = 4'b0000;
  end

  // Load alignment: addressed byte/half moved to bit 0 and extended.
  always_comb begin
    byte_v   = 8'(q >> {lat.addr[1:0], 3'b000});
    half_v   = lat.addr[1] ? q[31:16] : q[15:0];
    load_val = q;
    unique case (lat.size)
      SZ_BYTE: load_val = {{24{lat.sext & byte_v[7]}}, byte_v};
      SZ_HALF: load_val = {{16{lat.sext & half_v[15]}}, half_v};
      default: load_val = q;
    endcase
  end

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (be),
    .wdata (ram_wdata),
    .q     (q)
  );

  // Handshake FSM: accept, count wait states, fire the access, pulse ready.
  // NOTE: non-blocking assignments keep every register updating from
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      lat   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            lat   <= '{we: we, size: size_e'(size), sext: sext, addr: addr, wdata: wdata};
            cnt   <= 4'(WAIT_CYCLES);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_DONE;
            ready <= 1'b1;
            err   <= fault;
            if (fault)        rdata <= '0;
            else if (!lat.we) rdata <= rd_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
